// File: rtl/cast5_sbox_arb.sv
// cast5_sbox_arb: shares one CAST5 S-box lookup path between key expansion
// and the round datapath. Key expansion is served combinationally with
// absolute priority; the datapath gets a registered, block-long grant that
// is bounded by a hold counter.
module cast5_sbox_arb #(
    parameter int unsigned P_HOLD_MAX = 64,
    parameter int unsigned P_CNT_W    = 7
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_key_use,
    input  logic [31:0]    i_key_din,
    output logic [127:0]   o_key_dout,
    output logic           o_key_rdy,
    input  logic           i_dat_req,
    output logic           o_dat_gnt,
    input  logic [31:0]    i_dat_din,
    output logic [127:0]   o_dat_dout,
    input  logic           i_dat_done,
    output logic [31:0]    o_sbox_din,
    input  logic [127:0]   i_sbox_dout,
    input  logic           i_clr,
    output logic           o_err,
    output logic           o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [P_CNT_W-1:0] HOLD_LAST = P_CNT_W'(P_HOLD_MAX - 1);

    state_t             state;
    logic               pend;
    logic [P_CNT_W-1:0] hold_cnt;
    logic               dat_gnt_q;
    logic               err_q;
    logic               timeout_q;
    logic               key_sel;
    logic               dat_sel;

    // Owner select and S-box routing; key is served in its very first cycle
    always_comb begin
        key_sel    = (state == ST_KEY) || ((state == ST_IDLE) && i_key_use);
        dat_sel    = (state == ST_DATA);
        o_sbox_din = '0;
        if (key_sel) begin
            o_sbox_din = i_key_din;
        end else if (dat_sel) begin
            o_sbox_din = i_dat_din;
        end
        o_key_dout = key_sel ? i_sbox_dout : '0;
        o_dat_dout = dat_sel ? i_sbox_dout : '0;
        o_key_rdy  = (state != ST_DATA) &&
                     !((state == ST_IDLE) && i_dat_req && !i_key_use);
    end

    // Arbitration FSM with registered grant, hold counter and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            hold_cnt  <= '0;
            dat_gnt_q <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes precedence
            if (i_clr) begin
                err_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
            if ((state == ST_DATA) && i_key_use) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_key_use) begin
                        state <= ST_KEY;
                    end else if (i_dat_req) begin
                        state     <= ST_DATA;
                        dat_gnt_q <= 1'b1;
                        hold_cnt  <= '0;
                        pend      <= 1'b0;
                    end
                end
                ST_KEY: begin
                    if (i_key_use) begin
                        if (i_dat_req) begin
                            pend <= 1'b1;
                        end
                    end else if (i_dat_req || pend) begin
                        state     <= ST_DATA;
                        dat_gnt_q <= 1'b1;
                        hold_cnt  <= '0;
                        pend      <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // done outranks the timeout so a coincident done is clean
                    if (i_dat_done) begin
                        state     <= ST_IDLE;
                        dat_gnt_q <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_IDLE;
                        dat_gnt_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (!i_dat_req) begin
                        state     <= ST_IDLE;
                        dat_gnt_q <= 1'b0;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + P_CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dat_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_dat_gnt = dat_gnt_q;
    assign o_err     = err_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_cast5_sbox_arb.sv
// Scoreboard bench for cast5_sbox_arb: a stimulus process drives one cycle
// at a time and queues the expected outputs from an ownership-level model;
// a monitor pops and compares at each falling edge.
module tb_cast5_sbox_arb;

    localparam int HOLD = 64;
    localparam int OWN_NONE = 0;
    localparam int OWN_KEY  = 1;
    localparam int OWN_DATA = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_use;
    logic [31:0]  key_din;
    logic [127:0] key_dout;
    logic         key_rdy;
    logic         dat_req;
    logic         dat_gnt;
    logic [31:0]  dat_din;
    logic [127:0] dat_dout;
    logic         dat_done;
    logic [31:0]  sbox_din;
    logic [127:0] sbox_dout;
    logic         clr;
    logic         err;
    logic         tmo;

    cast5_sbox_arb #(.P_HOLD_MAX(HOLD), .P_CNT_W(7)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_use(key_use), .i_key_din(key_din), .o_key_dout(key_dout), .o_key_rdy(key_rdy),
        .i_dat_req(dat_req), .o_dat_gnt(dat_gnt), .i_dat_din(dat_din), .o_dat_dout(dat_dout),
        .i_dat_done(dat_done), .o_sbox_din(sbox_din), .i_sbox_dout(sbox_dout),
        .i_clr(clr), .o_err(err), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] kd;
        logic [127:0] dd;
        logic [31:0]  sd;
        logic         rdy;
        logic         gnt;
        logic         err;
        logic         to;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference: who owns the S-box, whether the datapath is owed a turn,
    // how many cycles it has held the grant, and the two sticky flags.
    int owner;
    bit owed;
    int age;
    bit m_err;
    bit m_to;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("key_dout", key_dout, e.kd);
            chk("dat_dout", dat_dout, e.dd);
            chk("sbox_din", {96'd0, sbox_din}, {96'd0, e.sd});
            chk("key_rdy", {127'd0, key_rdy}, {127'd0, e.rdy});
            chk("dat_gnt", {127'd0, dat_gnt}, {127'd0, e.gnt});
            chk("err", {127'd0, err}, {127'd0, e.err});
            chk("timeout", {127'd0, tmo}, {127'd0, e.to});
        end
    end

    task automatic model_reset();
        owner = OWN_NONE;
        owed  = 1'b0;
        age   = 0;
        m_err = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic step(input bit r, input bit ku, input logic [31:0] kdi,
                        input bit rq, input logic [31:0] ddi, input bit dn, input bit cl);
        exp_t e;
        bit   key_served;
        rst = r; key_use = ku; key_din = kdi; dat_req = rq; dat_din = ddi;
        dat_done = dn; clr = cl;
        sbox_dout = {$urandom, $urandom, $urandom, $urandom};

        key_served = (owner == OWN_KEY) || (owner == OWN_NONE && ku);
        e.sd  = key_served ? kdi : (owner == OWN_DATA) ? ddi : 32'd0;
        e.kd  = key_served ? sbox_dout : 128'd0;
        e.dd  = (owner == OWN_DATA) ? sbox_dout : 128'd0;
        e.rdy = (owner != OWN_DATA) && !(owner == OWN_NONE && rq && !ku);
        e.gnt = (owner == OWN_DATA);
        e.err = m_err;
        e.to  = m_to;
        q.push_back(e);

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (cl) begin
                m_err = 1'b0;
                m_to  = 1'b0;
            end
            if (owner == OWN_DATA && ku) m_err = 1'b1;
            if (owner == OWN_NONE) begin
                if (ku) owner = OWN_KEY;
                else if (rq) begin owner = OWN_DATA; age = 0; owed = 1'b0; end
            end else if (owner == OWN_KEY) begin
                if (ku) begin
                    if (rq) owed = 1'b1;
                end else if (rq || owed) begin
                    owner = OWN_DATA; age = 0; owed = 1'b0;
                end else begin
                    owner = OWN_NONE;
                end
            end else begin
                if (dn) owner = OWN_NONE;
                else if (age == HOLD - 1) begin owner = OWN_NONE; m_to = 1'b1; end
                else if (!rq) owner = OWN_NONE;
                else age++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_use = 0; key_din = 0; dat_req = 0; dat_din = 0;
        dat_done = 0; clr = 0; sbox_dout = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // T1: reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // T2: long key session, served from its first cycle
        for (int i = 0; i < 80; i++) step(0, 1, 32'h01020304, 0, 32'hdeadbeef, 0, 0);
        idle(2);

        // T3: datapath grant, done on cycle 17
        for (int i = 0; i < 17; i++) step(0, 0, 32'h11111111, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // T4: simultaneous rise, key wins, datapath follows
        for (int i = 0; i < 80; i++) step(0, 1, $urandom, 1, $urandom, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 1, 0);
        idle(2);

        // Pend keeps the datapath's turn after it stops requesting mid-key
        step(0, 1, $urandom, 0, 0, 0, 0);
        step(0, 1, $urandom, 1, 0, 0, 0);
        step(0, 1, $urandom, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // T5: conflicting key use during DATA, then clear
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'haabbccdd, 0, 0);
        step(0, 1, 32'h55555555, 1, 32'haabbccdd, 0, 0);
        step(0, 0, 0, 1, 32'haabbccdd, 0, 0);
        step(0, 0, 0, 1, 32'haabbccdd, 0, 1);
        step(0, 0, 0, 1, 32'haabbccdd, 1, 0);
        idle(2);

        // T6a: forced release after 64 grant cycles
        step(0, 0, 0, 1, $urandom, 0, 0);
        for (int i = 0; i < HOLD; i++) step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // T6b: done coincident with the last allowed cycle
        step(0, 0, 0, 1, $urandom, 0, 0);
        for (int i = 0; i < HOLD - 1; i++) step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Clear and set in the same cycle: set wins
        step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 1, $urandom, 1, $urandom, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        // Stray done with no grant is ignored; reset mid-session drops grant
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 0, 0);
        step(1, 0, 0, 1, $urandom, 0, 0);
        idle(2);

        // Randomized traffic with bursty key sessions
        begin
            bit ku = 0;
            bit rq = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 12) ku = !ku;
                if ($urandom_range(0, 99) < 8) rq = !rq;
                step(($urandom_range(0, 499) == 0), ku, $urandom, rq, $urandom,
                     ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 3));
            end
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
